pc_unit: RTL and testbench

- Parametrised program-counter unit for the single-cycle processor.
- Holds the architectural PC register and selects the next PC from the following sources: sequential, conditional branch, absolute jump, jump-register, exception vector.
- Supports a pipeline stall/hold.
- Optionally includes a return-address stack so call/return pairs resolve without a register read.
- Feeds instruction memory address and the link-value path.

---
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC select, stall and exception.
// Define PC_RAS_EN to add a circular return-address stack for call/return.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                PC_STEP   = 4,
    parameter int                BR_SHIFT  = 2,
    parameter int                JIDX_W    = 26,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 'h80,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              exc,
    input  logic              br_cond,
    input  logic              zero,
    input  logic [ADDR_W-1:0] br_off,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jidx,
    input  logic              link,
    input  logic              jreg,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              redirect,
    output logic              ras_empty
);

    localparam logic [ADDR_W-1:0] JMASK = {ADDR_W{1'b1}} << (JIDX_W + BR_SHIFT);

    logic [ADDR_W-1:0] r_pc;
    logic              r_redirect;
    logic [ADDR_W-1:0] w_pc_plus;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_jmp_tgt;
    logic [ADDR_W-1:0] w_next;
    logic              w_redir;
    logic              w_pop;
    logic [ADDR_W-1:0] w_top;

    assign w_pc_plus = r_pc + ADDR_W'(PC_STEP);
    assign w_br_tgt  = w_pc_plus + (br_off << BR_SHIFT);
    // Upper bits come from pc_plus; index and shift zeros fill the rest.
    assign w_jmp_tgt = (w_pc_plus & JMASK) | (ADDR_W'(jidx) << BR_SHIFT);

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]     r_ptr;
    logic [PW:0]       r_cnt;
    logic              w_push;

    // jreg outranks jump, so a push never coincides with a pop.
    assign w_push = jump & link & ~jreg & ~stall & ~exc;
    assign w_pop  = jreg & ret & ~stall & ~exc & (r_cnt != '0);
    assign w_top  = r_stack[r_ptr - 1'b1];
    assign ras_empty = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_stack[r_ptr] <= w_pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_cnt != (PW+1)'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_pop) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_unused  = link ^ ret;
    assign w_pop     = 1'b0;
    assign w_top     = '0;
    assign ras_empty = 1'b1;
`endif

    always_comb begin
        w_next  = w_pc_plus;
        w_redir = 1'b0;
        if (exc) begin
            w_next  = EXC_VEC;
            w_redir = 1'b1;
        end else if (stall) begin
            w_next  = r_pc;
        end else if (jreg) begin
            w_next  = w_pop ? w_top : jr_addr;
            w_redir = 1'b1;
        end else if (jump) begin
            w_next  = w_jmp_tgt;
            w_redir = 1'b1;
        end else if (br_cond && zero) begin
            w_next  = w_br_tgt;
            w_redir = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_VEC;
            r_redirect <= 1'b0;
        end else begin
            r_pc       <= w_next;
            r_redirect <= w_redir;
        end
    end

    assign pc       = r_pc;
    assign pc_plus  = w_pc_plus;
    assign redirect = r_redirect;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; RAS scenario active when PC_RAS_EN is defined.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, exc, br_cond, zero, jump, link, jreg, ret;
    logic [31:0] br_off, jr_addr;
    logic [25:0] jidx;
    logic [31:0] pc, pc_plus;
    logic        redirect, ras_empty;

    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .exc(exc),
        .br_cond(br_cond), .zero(zero), .br_off(br_off),
        .jump(jump), .jidx(jidx), .link(link), .jreg(jreg),
        .jr_addr(jr_addr), .ret(ret), .pc(pc), .pc_plus(pc_plus),
        .redirect(redirect), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        reset = 0; stall = 0; exc = 0; br_cond = 0; zero = 0;
        jump = 0; link = 0; jreg = 0; ret = 0;
        br_off = '0; jr_addr = '0; jidx = '0;
    endtask

    task automatic set_pc(input logic [31:0] a);
        clear();
        jreg = 1; jr_addr = a;
        step();
        clear();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        clear();
        reset = 1; stall = 1; jump = 1; jidx = 26'h3;
        step(); step();
        checks++;
        if (pc !== 32'h0 || redirect !== 1'b0 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset: pc=%h redir=%b empty=%b want 0/0/1", pc, redirect, ras_empty);
        end
        clear();
        for (int i = 1; i <= 3; i++) begin
            step();
            exp = 32'(4 * i);
            checks++;
            if (pc !== exp || redirect !== 1'b0) begin
                errors++;
                $display("FAIL seq%0d: pc=%h redir=%b want %h/0", i, pc, redirect, exp);
            end
        end
    endtask

    task automatic test_branch();
        set_pc(32'h10);
        checks++;
        if (pc_plus !== 32'h14) begin
            errors++;
            $display("FAIL pc_plus: got %h want 00000014", pc_plus);
        end
        br_cond = 1; zero = 1; br_off = 32'hFFFF_FFFE;
        step();
        checks++;
        if (pc !== 32'h0C || redirect !== 1'b1) begin
            errors++;
            $display("FAIL br_taken: pc=%h redir=%b want 0000000c/1", pc, redirect);
        end
        set_pc(32'h10);
        br_cond = 1; zero = 0; br_off = 32'hFFFF_FFFE;
        step();
        checks++;
        if (pc !== 32'h14 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL br_not_taken: pc=%h redir=%b want 00000014/0", pc, redirect);
        end
        clear();
    endtask

    task automatic test_jump();
        set_pc(32'h10);
        jump = 1; jidx = 26'h40;
        step();
        checks++;
        if (pc !== 32'h100 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL jump: pc=%h redir=%b want 00000100/1", pc, redirect);
        end
        set_pc(32'h10);
        jump = 1; jidx = 26'h40; jreg = 1; jr_addr = 32'h200;
        step();
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL jreg_over_jump: pc=%h want 00000200", pc);
        end
        set_pc(32'h10);
        jump = 1; jidx = 26'h40; br_cond = 1; zero = 1; br_off = 32'h8;
        step();
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL jump_over_br: pc=%h want 00000100", pc);
        end
        // upper bits kept from pc_plus
        set_pc(32'hF000_0010);
        jump = 1; jidx = 26'h1;
        step();
        checks++;
        if (pc !== 32'hF000_0004) begin
            errors++;
            $display("FAIL jump_upper: pc=%h want f0000004", pc);
        end
        clear();
    endtask

    task automatic test_stall();
        set_pc(32'h20);
        stall = 1; jump = 1; jidx = 26'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h20 || redirect !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: pc=%h redir=%b want 00000020/0", i, pc, redirect);
            end
        end
        exc = 1;
        step();
        checks++;
        if (pc !== 32'h80 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL exc_in_stall: pc=%h redir=%b want 00000080/1", pc, redirect);
        end
        clear();
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++;
        if (pc_plus !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus: got %h want 00000000", pc_plus);
        end
        step();
        checks++;
        if (pc !== 32'h0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL wrap: pc=%h redir=%b want 00000000/0", pc, redirect);
        end
    endtask

    task automatic test_ras();
`ifdef PC_RAS_EN
        logic [31:0] exp_ret [5];
        exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34;
        exp_ret[3] = 32'h24; exp_ret[4] = 32'hFFC;
        for (int i = 1; i <= 5; i++) begin
            set_pc(32'(16 * i));
            jump = 1; link = 1; jidx = 26'h100;
            step();
            clear();
        end
        checks++;
        if (ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL ras_full_empty: got %b want 0", ras_empty);
        end
        for (int i = 0; i < 5; i++) begin
            jreg = 1; ret = 1; jr_addr = 32'hFFC;
            step();
            checks++;
            if (pc !== exp_ret[i]) begin
                errors++;
                $display("FAIL ras_ret%0d: pc=%h want %h", i, pc, exp_ret[i]);
            end
            if (i == 3) begin
                checks++;
                if (ras_empty !== 1'b1) begin
                    errors++;
                    $display("FAIL ras_empty_after4: got %b want 1", ras_empty);
                end
            end
        end
`else
        set_pc(32'h10);
        jump = 1; link = 1; jidx = 26'h100;
        step();
        clear();
        jreg = 1; ret = 1; jr_addr = 32'hFFC;
        step();
        checks++;
        if (pc !== 32'hFFC || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL noras_ret: pc=%h empty=%b want 00000ffc/1", pc, ras_empty);
        end
`endif
        clear();
    endtask

    task automatic test_midreset();
`ifdef PC_RAS_EN
        set_pc(32'h40);
        jump = 1; link = 1; jidx = 26'h100;
        step();
        clear();
        checks++;
        if (ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL ras_pushed: empty=%b want 0", ras_empty);
        end
`endif
        set_pc(32'h40);
        reset = 1; stall = 1; jump = 1; jidx = 26'h40;
        step();
        checks++;
        if (pc !== 32'h0 || redirect !== 1'b0 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL midreset: pc=%h redir=%b empty=%b want 0/0/1", pc, redirect, ras_empty);
        end
        clear();
        jreg = 1; ret = 1; jr_addr = 32'hFFC;
        step();
        checks++;
        if (pc !== 32'hFFC) begin
            errors++;
            $display("FAIL ret_after_reset: pc=%h want 00000ffc", pc);
        end
        clear();
    endtask

    initial begin
        clear();
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_ras();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
